// File: rtl/bit_manip_unit.sv
// Sequential shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Result, carry and zero flag are held until the next accepted operation.
module bit_manip_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               carry_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_SAR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_RCL  = 3'd5,
    OP_RCR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  state_e             state, state_nx;
  op_e                op_q;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   step_data;
  logic               step_carry;

  // One single-bit step of the latched operation applied to the current result.
  always_comb begin
    step_data  = data_out;
    step_carry = carry;
    case (op_q)
      OP_SHL: begin
        step_data  = {data_out[WIDTH-2:0], 1'b0};
        step_carry = data_out[WIDTH-1];
      end
      OP_SHR: begin
        step_data  = {1'b0, data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      OP_SAR: begin
        step_data  = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      OP_ROL: begin
        step_data  = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
        step_carry = data_out[WIDTH-1];
      end
      OP_ROR: begin
        step_data  = {data_out[0], data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      OP_RCL: begin
        step_data  = {data_out[WIDTH-2:0], carry};
        step_carry = data_out[WIDTH-1];
      end
      OP_RCR: begin
        step_data  = {carry, data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      default: begin
        step_data  = data_out;
        step_carry = carry;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (amount == '0 || op == OP_PASS) ? DONE : RUN;
      RUN:  if (count == SHAMT_W'(1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_SHL;
      count    <= '0;
      data_out <= '0;
      carry    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          data_out <= data_in;
          op_q     <= op_e'(op);
          count    <= amount;
          carry    <= (op == OP_RCL || op == OP_RCR) ? carry_in : 1'b0;
        end
        RUN: begin
          data_out <= step_data;
          carry    <= step_carry;
          count    <= count - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (data_out == '0);

endmodule
